// File: rtl/pir_pkg.sv
// Shared constants for the PIR motion alarm: 7-segment glyphs, default
// threshold, counter saturation limits and the digit-to-glyph helper.
package pir_pkg;

  localparam int DATA_W = 7;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam int DEF_THRESHOLD = 50;

  localparam logic [DATA_W-1:0] SAT_DISPLAY = 7'd99;
  localparam logic [DATA_W-1:0] SAT_DETECT  = 7'd99;
  localparam logic [DATA_W-1:0] SAT_TOTAL   = 7'd127;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    seg_digit = SEG_0;
      4'd1:    seg_digit = SEG_1;
      4'd2:    seg_digit = SEG_2;
      4'd3:    seg_digit = SEG_3;
      4'd4:    seg_digit = SEG_4;
      4'd5:    seg_digit = SEG_5;
      4'd6:    seg_digit = SEG_6;
      4'd7:    seg_digit = SEG_7;
      4'd8:    seg_digit = SEG_8;
      4'd9:    seg_digit = SEG_9;
      default: seg_digit = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/pir_motion_detector_if.sv
// Sensor/arming inputs and LED/buzzer/display/counter outputs of the alarm.
// master = sensor front-end or bench side, slave = the detector core.
interface pir_motion_detector_if;
  import pir_pkg::*;

  logic              turn;
  logic              stop_alarm;
  logic [DATA_W-1:0] pir_sensor_1;
  logic [DATA_W-1:0] pir_sensor_2;
  logic [DATA_W-1:0] pir_sensor_3;

  logic [2:0]        LED;
  logic              buzzer;
  logic [6:0]        display_threshold_1;
  logic [6:0]        display_threshold_2;
  logic [6:0]        display_last_measurment_1;
  logic [6:0]        display_last_measurment_2;
  logic [6:0]        display_total_sensors_1;
  logic [6:0]        display_total_sensors_2;
  logic [DATA_W-1:0] check_counter;
  logic [DATA_W-1:0] check_counter_total;

  modport master (
    output turn, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    input  LED, buzzer,
    input  display_threshold_1, display_threshold_2,
    input  display_last_measurment_1, display_last_measurment_2,
    input  display_total_sensors_1, display_total_sensors_2,
    input  check_counter, check_counter_total
  );

  modport slave (
    input  turn, stop_alarm, pir_sensor_1, pir_sensor_2, pir_sensor_3,
    output LED, buzzer,
    output display_threshold_1, display_threshold_2,
    output display_last_measurment_1, display_last_measurment_2,
    output display_total_sensors_1, display_total_sensors_2,
    output check_counter, check_counter_total
  );

endinterface

// File: rtl/bin_to_7seg_2digit.sv
// Two-digit decimal 7-segment decoder; values above 99 display as 99.
module bin_to_7seg_2digit
  import pir_pkg::*;
(
  input  logic [DATA_W-1:0] value,
  output logic [6:0]        tens,
  output logic [6:0]        ones
);

  logic [DATA_W-1:0] clamped;
  logic [DATA_W-1:0] tens_val;
  logic [DATA_W-1:0] ones_val;

  always_comb begin
    clamped  = (value > SAT_DISPLAY) ? SAT_DISPLAY : value;
    tens_val = clamped / 7'd10;
    ones_val = clamped - tens_val * 7'd10;
    tens     = seg_digit(tens_val[3:0]);
    ones     = seg_digit(ones_val[3:0]);
  end

endmodule

// File: rtl/pir_motion_detector.sv
// Three-channel PIR alarm core: clamp, threshold, edge-detect, count, display.
// Define PIR_ALARM_LATCH_EN for a latched buzzer cleared by stop_alarm.
module pir_motion_detector
  import pir_pkg::*;
#(
  parameter int THRESHOLD = DEF_THRESHOLD
) (
  input  logic                 clk,
  input  logic                 rst,
  pir_motion_detector_if.slave bus
);

  localparam logic [DATA_W-1:0] THR = DATA_W'(THRESHOLD);

  function automatic logic [DATA_W-1:0] sat_display(input logic [DATA_W-1:0] v);
    sat_display = (v > SAT_DISPLAY) ? SAT_DISPLAY : v;
  endfunction

  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v,
                                                input logic [DATA_W-1:0] lim);
    sat_inc = (v < lim) ? v + 7'd1 : lim;
  endfunction

  logic [DATA_W-1:0] val_1, val_2, val_3;
  logic [2:0]        trig;
  logic              any_now;
  logic              detect;
  logic [DATA_W-1:0] first_val;
  logic [1:0]        trig_cnt;

  logic [2:0]        led_p1;
  logic              any_p1;
  logic              buzz_p1;
  logic [1:0]        trig_cnt_p1;
  logic [DATA_W-1:0] last_p1;
  logic [DATA_W-1:0] det_cnt_p1;
  logic [DATA_W-1:0] tot_cnt_p1;

  // Stage 0: clamp, compare against threshold, detect rising edge of any
  always_comb begin
    val_1   = sat_display(bus.pir_sensor_1);
    val_2   = sat_display(bus.pir_sensor_2);
    val_3   = sat_display(bus.pir_sensor_3);
    trig[0] = bus.turn && (val_1 >= THR);
    trig[1] = bus.turn && (val_2 >= THR);
    trig[2] = bus.turn && (val_3 >= THR);
    any_now = |trig;
    detect  = any_now && !any_p1;
    if (trig[0])      first_val = val_1;
    else if (trig[1]) first_val = val_2;
    else              first_val = val_3;
    trig_cnt = {1'b0, trig[0]} + {1'b0, trig[1]} + {1'b0, trig[2]};
  end

`ifndef PIR_ALARM_LATCH_EN
  logic unused_stop;
  assign unused_stop = bus.stop_alarm;
`endif

  // Stage 1: registered outputs and event state
  always_ff @(posedge clk) begin
    if (rst) begin
      led_p1      <= '0;
      any_p1      <= 1'b0;
      buzz_p1     <= 1'b0;
      trig_cnt_p1 <= '0;
      last_p1     <= '0;
      det_cnt_p1  <= '0;
      tot_cnt_p1  <= '0;
    end else begin
      led_p1      <= trig;
      any_p1      <= any_now;
      trig_cnt_p1 <= trig_cnt;
      if (detect) begin
        last_p1    <= first_val;
        det_cnt_p1 <= sat_inc(det_cnt_p1, SAT_DETECT);
      end
      if (bus.turn)
        tot_cnt_p1 <= sat_inc(tot_cnt_p1, SAT_TOTAL);
`ifdef PIR_ALARM_LATCH_EN
      if (!bus.turn || bus.stop_alarm)
        buzz_p1 <= 1'b0;
      else if (detect)
        buzz_p1 <= 1'b1;
`else
      buzz_p1 <= any_now;
`endif
    end
  end

  assign bus.LED                 = led_p1;
  assign bus.buzzer              = buzz_p1;
  assign bus.check_counter       = det_cnt_p1;
  assign bus.check_counter_total = tot_cnt_p1;

  bin_to_7seg_2digit u_thr_disp (
    .value (THR),
    .tens  (bus.display_threshold_1),
    .ones  (bus.display_threshold_2)
  );

  bin_to_7seg_2digit u_last_disp (
    .value (last_p1),
    .tens  (bus.display_last_measurment_1),
    .ones  (bus.display_last_measurment_2)
  );

  bin_to_7seg_2digit u_total_disp (
    .value ({5'd0, trig_cnt_p1}),
    .tens  (bus.display_total_sensors_1),
    .ones  (bus.display_total_sensors_2)
  );

endmodule

// File: tb/tb_pir_motion_detector.sv
// Directed bench for pir_motion_detector; expectations follow the build's
// PIR_ALARM_LATCH_EN setting.
module tb_pir_motion_detector;

`ifdef PIR_ALARM_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0010000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_tot  = 0;

  pir_motion_detector_if bus ();

  pir_motion_detector #(.THRESHOLD(50)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) exp_tot = 0;
    else if (bus.turn && exp_tot < 127) exp_tot++;
    #1;
  endtask

  task automatic set_s(input int a, input int b, input int c);
    bus.pir_sensor_1 = 7'(a);
    bus.pir_sensor_2 = 7'(b);
    bus.pir_sensor_3 = 7'(c);
  endtask

  task automatic chk_last(input string tag, input logic [6:0] t, input logic [6:0] o);
    check({tag, "_last_t"}, int'(bus.display_last_measurment_1), int'(t));
    check({tag, "_last_o"}, int'(bus.display_last_measurment_2), int'(o));
  endtask

  task automatic chk_total(input string tag, input logic [6:0] t, input logic [6:0] o);
    check({tag, "_tot_t"}, int'(bus.display_total_sensors_1), int'(t));
    check({tag, "_tot_o"}, int'(bus.display_total_sensors_2), int'(o));
  endtask

  initial begin
    rst = 1'b1;
    bus.turn = 1'b0;
    bus.stop_alarm = 1'b0;
    set_s(0, 0, 0);
    step();
    step();
    check("rst_led", int'(bus.LED), 0);
    check("rst_buzz", int'(bus.buzzer), 0);
    check("rst_cc", int'(bus.check_counter), 0);
    check("rst_cct", int'(bus.check_counter_total), 0);
    check("rst_thr_t", int'(bus.display_threshold_1), int'(S5));
    check("rst_thr_o", int'(bus.display_threshold_2), int'(S0));
    chk_last("rst", S0, S0);
    chk_total("rst", S0, S0);

    // Just below threshold
    rst = 1'b0;
    bus.turn = 1'b1;
    set_s(49, 0, 0);
    step();
    check("below_led", int'(bus.LED), 0);
    check("below_buzz", int'(bus.buzzer), 0);
    check("below_cc", int'(bus.check_counter), 0);
    check("below_cct", int'(bus.check_counter_total), 1);

    // At threshold
    set_s(50, 0, 0);
    step();
    check("at_led", int'(bus.LED), 1);
    check("at_buzz", int'(bus.buzzer), 1);
    check("at_cc", int'(bus.check_counter), 1);
    check("at_cct", int'(bus.check_counter_total), 2);
    chk_last("at", S5, S0);
    chk_total("at", S0, S1);

    step();
    check("hold_cc", int'(bus.check_counter), 1);
    check("hold_buzz", int'(bus.buzzer), 1);

    // Stop priority
    bus.stop_alarm = 1'b1;
    step();
    check("stop_buzz", int'(bus.buzzer), LATCH ? 0 : 1);
    bus.stop_alarm = 1'b0;
    set_s(0, 0, 0);
    step();
    check("drop_buzz", int'(bus.buzzer), 0);
    check("drop_led", int'(bus.LED), 0);
    bus.stop_alarm = 1'b1;
    set_s(50, 0, 0);
    step();
    check("stopedge_buzz", int'(bus.buzzer), LATCH ? 0 : 1);
    check("stopedge_cc", int'(bus.check_counter), 2);
    bus.stop_alarm = 1'b0;
    step();
    check("noedge_buzz", int'(bus.buzzer), LATCH ? 0 : 1);
    check("noedge_cc", int'(bus.check_counter), 2);
    set_s(0, 0, 0);
    step();
    set_s(50, 0, 0);
    step();
    check("fresh_buzz", int'(bus.buzzer), 1);
    check("fresh_cc", int'(bus.check_counter), 3);

    // All three sensors, one clamped
    set_s(0, 0, 0);
    step();
    set_s(99, 60, 120);
    step();
    check("all_led", int'(bus.LED), 7);
    check("all_cc", int'(bus.check_counter), 4);
    chk_total("all", S0, S3);
    chk_last("all", S9, S9);

    // Lowest-numbered triggered sensor is stored
    set_s(0, 0, 0);
    step();
    set_s(10, 70, 120);
    step();
    check("low_led", int'(bus.LED), 6);
    check("low_cc", int'(bus.check_counter), 5);
    chk_last("low", S7, S0);
    chk_total("low", S0, S2);

    set_s(0, 0, 0);
    step();
    set_s(0, 0, 120);
    step();
    check("clamp_led", int'(bus.LED), 4);
    chk_last("clamp", S9, S9);
    check("clamp_cc", int'(bus.check_counter), 6);

    // Disarm and re-arm
    bus.turn = 1'b0;
    set_s(80, 0, 0);
    step();
    check("dis_led", int'(bus.LED), 0);
    check("dis_buzz", int'(bus.buzzer), 0);
    check("dis_cc", int'(bus.check_counter), 6);
    check("dis_cct", int'(bus.check_counter_total), exp_tot);
    chk_total("dis", S0, S0);
    chk_last("dis", S9, S9);
    bus.turn = 1'b1;
    step();
    check("rearm_led", int'(bus.LED), 1);
    check("rearm_buzz", int'(bus.buzzer), 1);
    check("rearm_cc", int'(bus.check_counter), 7);
    chk_last("rearm", S8, S0);

    // Saturation
    for (int i = 0; i < 130; i++) begin
      set_s(0, 0, 0);
      step();
      set_s(60, 0, 0);
      step();
    end
    check("sat_cc", int'(bus.check_counter), 99);
    check("sat_cct", int'(bus.check_counter_total), 127);
    check("sat_cct_model", int'(bus.check_counter_total), exp_tot);
    check("sat_buzz", int'(bus.buzzer), 1);

    // Reset mid-alarm
    rst = 1'b1;
    step();
    check("mrst_buzz", int'(bus.buzzer), 0);
    check("mrst_led", int'(bus.LED), 0);
    check("mrst_cc", int'(bus.check_counter), 0);
    check("mrst_cct", int'(bus.check_counter_total), 0);
    chk_last("mrst", S0, S0);
    rst = 1'b0;
    bus.turn = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
